muldiv: RTL and testbench

MULDIV -- requirements
Module: muldiv

---
 rtl/muldiv.sv | 165 ++++++++++++++++
 tb/tb_muldiv.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv.sv
// muldiv: iterative RISC-V M-extension multiply/divide unit.
// Multiply is radix-2 shift-add and divide is radix-2 restoring.
// Both run on operand magnitudes, and the sign is fixed up on the last step.
// A divide by zero, or the signed overflow case (most-negative / -1), finishes
// the cycle after accept.
// Optional macro MULDIV_FAST_MUL_EN: all four multiply ops use a single-cycle
// combinational product and complete like the early-out divide cases.
module muldiv #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   LAST     = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   res;

    // Operation context captured at accept.
    logic [2:0]        op;
    logic              neg;
    logic [XLEN-1:0]   hi, lo, opb;

    // Request decode and operand preparation.
    logic              accept, a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, early;
    logic [XLEN-1:0]   early_res;

    // One iteration step, plus the sign-corrected final result.
    logic [XLEN:0]     msum, shifted, diff;
    logic              ge;
    logic [XLEN-1:0]   hi_n, lo_n, qr, fin;
    logic [2*XLEN-1:0] prod, pfix;
    logic              last;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fprod;
`endif

    assign o_ready  = (state == IDLE);
    assign o_valid  = (state == DONE);
    assign o_result = res;
    assign accept   = i_valid && (state == IDLE) && !i_flush;
    assign last     = (cnt == LAST);

    // Decode signedness, form magnitudes and detect the early-out cases.
    always_comb begin
        a_signed  = (i_op == 3'b001) || (i_op == 3'b010) || (i_op == 3'b100) || (i_op == 3'b110);
        b_signed  = (i_op == 3'b001) || (i_op == 3'b100) || (i_op == 3'b110);
        a_neg     = a_signed && i_a[XLEN-1];
        b_neg     = b_signed && i_b[XLEN-1];
        a_mag     = a_neg ? -i_a : i_a;
        b_mag     = b_neg ? -i_b : i_b;
        // The remainder follows the dividend; everything else is the product of signs.
        neg_in    = (i_op == 3'b110) ? a_neg : (a_neg ^ b_neg);
        div_zero  = i_op[2] && (i_b == '0);
        div_ovf   = ((i_op == 3'b100) || (i_op == 3'b110)) && (i_a == MOST_NEG) && (&i_b);
        early     = div_zero || div_ovf;
        early_res = '0;
        if (div_zero)
            early_res = i_op[1] ? i_a : '1;
        else if (div_ovf)
            early_res = i_op[1] ? '0 : MOST_NEG;
`ifdef MULDIV_FAST_MUL_EN
        fprod = {{XLEN{a_neg}}, i_a} * {{XLEN{b_neg}}, i_b};
        if (!i_op[2]) begin
            early     = 1'b1;
            early_res = (i_op[1:0] == 2'b00) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
        end
`endif
    end

    // Iteration step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        msum    = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, opb};
        ge      = !diff[XLEN];
        if (op[2]) begin
            hi_n = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], ge};
        end else begin
            hi_n = msum[XLEN:1];
            lo_n = {msum[0], lo[XLEN-1:1]};
        end
        prod = {hi_n, lo_n};
        pfix = neg ? -prod : prod;
        qr   = op[1] ? hi_n : lo_n;
        if (op[2])
            fin = neg ? -qr : qr;
        else
            fin = (op[1:0] == 2'b00) ? pfix[XLEN-1:0] : pfix[2*XLEN-1:XLEN];
    end

    // Next-state logic; flush overrides accept and result handoff.
    always_comb begin
        state_nxt = state;
        if (i_flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = early ? DONE : BUSY;
                BUSY:    if (last) state_nxt = DONE;
                DONE:    if (i_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Iteration counter and result register; the result is zero outside DONE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
            res <= '0;
        end else if (i_flush) begin
            cnt <= '0;
            res <= '0;
        end else begin
            cnt <= (state == BUSY && !last) ? cnt + 1'b1 : '0;
            case (state)
                IDLE:    if (accept && early) res <= early_res;
                BUSY:    if (last) res <= fin;
                DONE:    if (i_ready) res <= '0;
                default: res <= '0;
            endcase
        end
    end

    // Datapath registers: load magnitudes on accept, then step while busy.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            op  <= i_op;
            neg <= neg_in;
            hi  <= '0;
            lo  <= i_op[2] ? a_mag : b_mag;
            opb <= i_op[2] ? b_mag : a_mag;
        end else if (state == BUSY) begin
            hi  <= hi_n;
            lo  <= lo_n;
        end
    end

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: randomized and directed self-checking bench for muldiv.
// The reference model uses plain 64-bit arithmetic on the RISC-V semantics.
module tb_muldiv;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, i_flush, i_ready;
    logic [2:0]  i_op;
    logic [31:0] i_a, i_b;
    logic        o_ready, o_valid;
    logic [31:0] o_result;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv #(.XLEN(XLEN)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return MUL_LAT;
        if (b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == MIN && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return MIN;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called #1 after a rising edge with the unit idle.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input int hold);
        int lat;
        check({tag, ":ready"}, o_ready, 1);
        i_valid = 1'b1; i_op = op; i_a = a; i_b = b;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_op = 3'($urandom); i_a = $urandom; i_b = $urandom;
        lat = 1;
        while (!o_valid && lat < 200) begin
            @(posedge i_clk); #1;
            lat++;
        end
        check({tag, ":lat"}, lat, exp_lat);
        check({tag, ":res"}, o_result, exp_res);
        check({tag, ":busy_ready"}, o_ready, 0);
        for (int k = 0; k < hold; k++) begin
            @(posedge i_clk); #1;
            check({tag, ":hold_valid"}, o_valid, 1);
            check({tag, ":hold_res"}, o_result, exp_res);
            check({tag, ":hold_ready"}, o_ready, 0);
        end
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        check({tag, ":post_valid"}, o_valid, 0);
        check({tag, ":post_res"}, o_result, 0);
        check({tag, ":post_ready"}, o_ready, 1);
    endtask

    // Called #1 after a rising edge; leaves the unit in BUSY cycle 10 of a long divide.
    task automatic start_busy10();
        i_valid = 1'b1; i_op = 3'd5; i_a = 32'd100; i_b = 32'd7;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (10) begin @(posedge i_clk); #1; end
    endtask

    initial begin
        int pulses;
        logic [2:0]  op;
        logic [31:0] a, b;
        i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        i_op = '0; i_a = '0; i_b = '0;

        repeat (3) @(posedge i_clk);
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_result", o_result, 0);
        @(negedge i_clk) i_rst = 1'b0;
        @(posedge i_clk); #1;
        check("rst_ready", o_ready, 1);

        // Directed corner cases.
        do_op("div_neg",  3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, XLEN + 1, 0);
        do_op("rem_neg",  3'd6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, XLEN + 1, 0);
        do_op("divu_z",   3'd5, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1, 0);
        do_op("remu_z",   3'd7, 32'h1234, 32'h0, 32'h0000_1234, 1, 0);
        do_op("div_ovf",  3'd4, MIN, 32'hFFFF_FFFF, MIN, 1, 0);
        do_op("rem_ovf",  3'd6, MIN, 32'hFFFF_FFFF, 32'h0, 1, 0);
        do_op("mulh_min", 3'd1, MIN, MIN, 32'h4000_0000, MUL_LAT, 0);
        do_op("mulhsu",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 0);
        do_op("mul_m1",   3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, MUL_LAT, 0);
        do_op("hold5",    3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, XLEN + 1, 5);

        // Flush mid-operation: idle next cycle and no result pulse afterwards.
        start_busy10();
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        check("flush_ready", o_ready, 1);
        check("flush_valid", o_valid, 0);
        pulses = 0;
        repeat (40) begin
            @(posedge i_clk); #1;
            if (o_valid) pulses++;
        end
        check("flush_no_pulse", pulses, 0);

        // Flush wins over a simultaneous accept.
        i_valid = 1'b1; i_flush = 1'b1; i_op = 3'd4; i_a = 32'd100; i_b = 32'd7;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        check("flush_vs_accept", o_ready, 1);

        // Flush wins over i_ready in DONE.
        i_valid = 1'b1; i_op = 3'd5; i_a = 32'd100; i_b = 32'd0;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        check("done_valid", o_valid, 1);
        i_flush = 1'b1; i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0; i_ready = 1'b0;
        check("done_flush_valid", o_valid, 0);
        check("done_flush_res", o_result, 0);
        check("done_flush_ready", o_ready, 1);

        // Reset mid-operation takes effect without waiting for a clock edge.
        start_busy10();
        i_rst = 1'b1;
        #1;
        check("arst_busy_valid", o_valid, 0);
        check("arst_busy_res", o_result, 0);
        @(negedge i_clk) i_rst = 1'b0;
        @(posedge i_clk); #1;
        check("arst_busy_ready", o_ready, 1);
        do_op("divu_10_3", 3'd5, 32'd10, 32'd3, 32'd3, XLEN + 1, 0);

        // Reset while a result is held clears it immediately.
        i_valid = 1'b1; i_op = 3'd7; i_a = 32'h55; i_b = 32'd0;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        check("pre_arst_res", o_result, 32'h55);
        i_rst = 1'b1;
        #1;
        check("arst_done_valid", o_valid, 0);
        check("arst_done_res", o_result, 0);
        @(negedge i_clk) i_rst = 1'b0;
        @(posedge i_clk); #1;

        // Randomized operations against the reference model.
        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            do_op($sformatf("rand%0d_op%0d", i, op), op, a, b, model(op, a, b), lat_model(op, a, b),
                  int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
